// File: rtl/mod255_adder_arbiter.sv
// Round-robin front end sharing one modulo 2^8-1 end-around-carry adder among NREQ requesters.
// Two-stage valid/ready pipeline; responses carry the issuing requester's index.
module mod255_adder_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_sum,
  output logic [ID_W-1:0]      rsp_id
);

  logic [ID_W-1:0] r_rr_ptr;
  logic            r_s1_valid;
  logic [7:0]      r_s1_a;
  logic [7:0]      r_s1_b;
  logic [ID_W-1:0] r_s1_id;
  logic            r_rsp_valid;
  logic [7:0]      r_rsp_sum;
  logic [ID_W-1:0] r_rsp_id;

  logic            w_found;
  logic [ID_W-1:0] w_win;
  logic            w_s2_load;
  logic            w_s1_adv;
  logic            w_s1_free;
  logic            w_accept;
  logic [7:0]      w_core_sum;

  // End-around carry: the carry out of bit 7 re-enters at bit 0; max 0x1FE+1 never overflows.
  function automatic logic [7:0] core_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

  assign w_s2_load = ~r_rsp_valid | rsp_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_load;
  assign w_s1_free = ~r_s1_valid | w_s2_load;
  assign w_accept  = en & w_s1_free & w_found;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_win] = 1'b1;
    end
  end

  assign w_core_sum = core_add(r_s1_a, r_s1_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= ID_W'(NREQ - 1);
      r_s1_valid  <= 1'b0;
      r_s1_a      <= 8'h00;
      r_s1_b      <= 8'h00;
      r_s1_id     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= 8'h00;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_win;
        r_s1_a   <= req_a[8*w_win +: 8];
        r_s1_b   <= req_b[8*w_win +: 8];
        r_s1_id  <= w_win;
      end
      r_s1_valid <= w_accept | (r_s1_valid & ~w_s1_adv);
      if (w_s2_load) begin
        r_rsp_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rsp_sum <= w_core_sum;
          r_rsp_id  <= r_s1_id;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_mod255_adder_arbiter.sv
// Directed bench for mod255_adder_arbiter: table of single ops plus hand-written
// round-robin, stall, enable-drain and mid-flight reset sequences.
module tb_mod255_adder_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_sum;
  logic [ID_W-1:0]   rsp_id;

  mod255_adder_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
  } vec_t;

  vec_t single_v[5];
  vec_t rr_v[4];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    single_v[0] = '{a: 8'h80, b: 8'h80, sum: 8'h01};
    single_v[1] = '{a: 8'h01, b: 8'hFE, sum: 8'hFF};
    single_v[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFF};
    single_v[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00};
    single_v[4] = '{a: 8'h7F, b: 8'h01, sum: 8'h80};
    rr_v[0] = '{a: 8'h80, b: 8'h80, sum: 8'h01};
    rr_v[1] = '{a: 8'hF0, b: 8'h20, sum: 8'h11};
    rr_v[2] = '{a: 8'h12, b: 8'h34, sum: 8'h46};
    rr_v[3] = '{a: 8'hFE, b: 8'h03, sum: 8'h02};

    rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_sum", 32'(rsp_sum), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("idle req_ready", 32'(req_ready), 0);

    // Isolated ops through requester 0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 4'b0001; req_a[7:0] = single_v[i].a; req_b[7:0] = single_v[i].b;
      #1;
      chk("single req_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("single latency gap", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("single rsp_valid", 32'(rsp_valid), 1);
      chk("single rsp_sum", 32'(rsp_sum), 32'(single_v[i].sum));
      chk("single rsp_id", 32'(rsp_id), 0);
    end

    // Fresh reset so requester 0 has top priority again
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8] = rr_v[i].a;
      req_b[8*i +: 8] = rr_v[i].b;
    end

    // All four valid: grants 0,1,2,3,0,1 with responses two cycles behind
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk("rr rsp_valid", 32'(rsp_valid), 1);
        chk("rr rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
        chk("rr rsp_sum", 32'(rsp_sum), 32'(rr_v[(c - 2) % 4].sum));
      end
      @(negedge clk);
    end

    // Downstream stall: both stages full, no grants, outputs frozen on op from req0
    for (int s = 0; s < 3; s++) begin
      rsp_ready = 1'b0;
      #1;
      chk("stall req_ready", 32'(req_ready), 0);
      chk("stall rsp_valid", 32'(rsp_valid), 1);
      chk("stall rsp_id", 32'(rsp_id), 0);
      chk("stall rsp_sum", 32'(rsp_sum), 32'(rr_v[0].sum));
      @(negedge clk);
    end
    for (int r = 0; r < 4; r++) begin
      rsp_ready = 1'b1;
      #1;
      chk("release grant", 32'(req_ready), 32'(1 << ((2 + r) % 4)));
      chk("release rsp_valid", 32'(rsp_valid), 1);
      chk("release rsp_id", 32'(rsp_id), 32'(r));
      chk("release rsp_sum", 32'(rsp_sum), 32'(rr_v[r].sum));
      @(negedge clk);
    end

    // en low: in-flight ops (req0, req1) drain, no grants
    en = 1'b0; req_valid = 4'b0110;
    #1;
    chk("en0 req_ready a", 32'(req_ready), 0);
    chk("en0 drain id a", 32'(rsp_id), 0);
    chk("en0 drain valid a", 32'(rsp_valid), 1);
    @(negedge clk); #1;
    chk("en0 req_ready b", 32'(req_ready), 0);
    chk("en0 drain id b", 32'(rsp_id), 1);
    chk("en0 drain sum b", 32'(rsp_sum), 32'(rr_v[1].sum));
    @(negedge clk); #1;
    chk("en0 empty", 32'(rsp_valid), 0);
    chk("en0 req_ready c", 32'(req_ready), 0);
    @(negedge clk);
    en = 1'b1;
    #1;
    chk("en1 resume grant", 32'(req_ready), 32'h4);
    @(negedge clk); #1;
    chk("en1 next grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b1111; rsp_ready = 1'b0;
    #1;
    chk("pre-reset rsp_id", 32'(rsp_id), 2);
    chk("pre-reset full", 32'(req_ready), 0);

    // Async reset mid-cycle with two ops in flight
    #2 rst = 1'b1;
    #1;
    chk("async rst rsp_valid", 32'(rsp_valid), 0);
    chk("async rst rsp_id", 32'(rsp_id), 0);
    chk("async rst rsp_sum", 32'(rsp_sum), 0);
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("post-rst grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("post-rst no stale rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("post-rst rsp_valid", 32'(rsp_valid), 1);
    chk("post-rst rsp_id", 32'(rsp_id), 0);
    chk("post-rst rsp_sum", 32'(rsp_sum), 32'(rr_v[0].sum));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mod255_adder_arbiter.md
Name: mod255_adder_arbiter

Overview:
- Shares one 8-bit end-around-carry Ling adder core (L8_node_adder, modulo 2^8-1) among NREQ requesters.
- Round-robin arbitration, two-stage valid/ready pipeline around the combinational core, responses tagged with requester ID.
- Sits between residue-channel producers and the single modulo adder instance, so the core is not replicated per client.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID tag, must be at least ceil(log2(NREQ))

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  1 = grants allowed; 0 = no new grants, in-flight ops drain
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_a  input  8*NREQ  operand A, requester i in bits [8i+7:8i]
req_b  input  8*NREQ  operand B, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accept
rsp_sum  output  8  modulo 2^8-1 sum
rsp_id  output  ID_W  requester index that issued the op

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_sum=0x00, rsp_id=0, s1_valid=0, rr_ptr=NREQ-1. After reset, requester 0 has top priority.
- Handshakes: req transfer on req_valid[i] & req_ready[i]. rsp transfer on rsp_valid & rsp_ready.
  - req_ready may depend combinationally on req_valid.
  - A requester must hold its valid/operands until accepted.
  - rsp_valid/rsp_sum/rsp_id stay stable while rsp_valid & !rsp_ready.
- Arbitration:
  - Candidates are requesters with req_valid=1.
  - Winner is the first candidate searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - req_ready[winner] = en & s1_free; all other req_ready are 0.
  - rr_ptr <= winner only on a completed req handshake; otherwise unchanged.
- Pipeline:
  - s2_load = !rsp_valid | rsp_ready.
  - s1_adv = s1_valid & s2_load.
  - s1_free = !s1_valid | s2_load.
  - Stage 1 registers a, b, id on accept; s1_valid <= accepted | (s1_valid & !s1_adv).
  - Stage 2: when s2_load, rsp_valid <= s1_valid, and on s1_valid also rsp_sum <= core(s1_a,s1_b), rsp_id <= s1_id.
- Latency: accept at edge N produces rsp_valid high after edge N+1 (first response cycle is 2 cycles after the accept cycle when unstalled).
- Throughput: 1 op/cycle. Max 2 ops in flight; no op lost or duplicated under any rsp_ready pattern.
- Arithmetic (fixed by the core): s = a+b (9 bits).
  - s <= 255: result = s[7:0], so a+b=255 yields 0xFF.
  - s > 255: result = s[7:0]+1.
  - 0x00 only for 0+0. 0xFF is the second zero representation and is not normalised.
- en=0: req_ready all 0. Pipeline keeps draining. rr_ptr frozen.
- Simultaneous rsp pop and new accept in the same cycle are both permitted (full-rate streaming).
- Reset mid-operation: in-flight ops are discarded, no response emitted. rr_ptr returns to NREQ-1.
- Single requester only: that requester is granted every cycle.
- All req_valid low: pipeline bubbles advance normally.

Test Plan:
- Reset then idle -> rsp_valid=0, req_ready=0000 while no valid; assert rst async mid-cycle -> outputs clear before next edge.
- Single op, req0 a=0x80 b=0x80, rsp_ready=1 -> req_ready[0]=1 that cycle; rsp_valid high one cycle after the accept edge with rsp_sum=0x01, rsp_id=0. Also check 0x01+0xFE -> 0xFF, 0xFF+0xFF -> 0xFF, 0x00+0x00 -> 0x00, 0x7F+0x01 -> 0x80.
- All 4 req_valid held high, distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0,1 and one response per cycle, ids in the same order.
- rsp_ready low for 3 cycles with continuous requests -> exactly 2 ops buffered, req_ready=0000 during the stall, rsp outputs stable; release -> responses resume in order, none lost or duplicated.
- en=0 with req1,req2 valid and 2 ops in flight -> no grants, both in-flight responses drain; en=1 -> grant resumes at rr_ptr+1.
- Reset asserted with 2 ops in flight -> no response emitted after reset release; next grant goes to requester 0 when all requesters are valid.
